cordic_iter_engine: RTL and testbench

CORDIC_ITER_ENGINE -- requirements
Module: cordic_iter_engine

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_step.sv | 48 ++++
 rtl/cordic_iter_engine.sv | 135 +++++++++++++
 tb/tb_cordic_iter_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the iterative CORDIC engine:
//   - state_t          : engine FSM states
//   - ATAN_TAB         : atan(2^-s),  s = 0..15, unsigned Q3.29
//   - ATANH_TAB        : atanh(2^-s), s = 1..15, unsigned Q3.29 (entry 0 unused)
//   - HYP_REPEAT_S_A/B : hyperbolic shift values executed twice when the
//                        CORDIC_HYP_REPEAT_EN build option is enabled
//   - first_shift()    : initial shift value for a coordinate system
// The engine keeps only the top WIDTH bits of each table entry, which gives
// an angle in Q3.(WIDTH-3) truncated toward zero.
// -----------------------------------------------------------------------------
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SHIFT_W = 4;
    localparam int TAB_W   = 32;

    localparam logic [SHIFT_W-1:0] HYP_REPEAT_S_A = 4'd4;
    localparam logic [SHIFT_W-1:0] HYP_REPEAT_S_B = 4'd13;

    localparam logic [TAB_W-1:0] ATAN_TAB [16] = '{
        32'd421657428, 32'd248918914, 32'd131521918, 32'd66762579,
        32'd33510843,  32'd16771757,  32'd8387925,   32'd4194218,
        32'd2097141,   32'd1048574,   32'd524287,    32'd262143,
        32'd131071,    32'd65535,     32'd32767,     32'd16383
    };

    // atanh(1) is unbounded; the hyperbolic sequence never uses index 0.
    localparam logic [TAB_W-1:0] ATANH_TAB [16] = '{
        32'd0,         32'd294906490, 32'd137123709, 32'd67461702,
        32'd33598225,  32'd16782680,  32'd8389290,   32'd4194389,
        32'd2097162,   32'd1048577,   32'd524288,    32'd262144,
        32'd131072,    32'd65536,     32'd32768,     32'd16384
    };

    // Circular starts at s=0, hyperbolic at s=1.
    function automatic logic [SHIFT_W-1:0] first_shift(input logic hyp);
        return SHIFT_W'(hyp);
    endfunction

endpackage

// File: rtl/cordic_step.sv
// -----------------------------------------------------------------------------
// cordic_step
// One combinational CORDIC micro-rotation with a built-in angle lookup.
//   x, y, z      in  WIDTH  current vector and residual angle (signed)
//   s            in  4      shift amount for this step
//   m            in  1      0 = circular, 1 = hyperbolic
//   vec          in  1      0 = rotation (steer z to 0), 1 = vectoring (y to 0)
//   x_next ...   out WIDTH  updated vector and angle
// All sums are WIDTH bits and wrap on overflow.
// -----------------------------------------------------------------------------
module cordic_step
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]   x,
    input  logic signed [WIDTH-1:0]   y,
    input  logic signed [WIDTH-1:0]   z,
    input  logic        [SHIFT_W-1:0] s,
    input  logic                      m,
    input  logic                      vec,
    output logic signed [WIDTH-1:0]   x_next,
    output logic signed [WIDTH-1:0]   y_next,
    output logic signed [WIDTH-1:0]   z_next
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;
    logic signed [WIDTH-1:0] angle;
    logic                    d_pos;
    logic                    x_sub;

    // NOTE: every output is assigned on every path through this block, so no
    // latch can be inferred; keep it that way when adding cases.
    always_comb begin
        angle  = WIDTH'((m ? ATANH_TAB[s] : ATAN_TAB[s]) >> (TAB_W - WIDTH));
        x_sh   = x >>> s;
        y_sh   = y >>> s;
        // d = +1 when z is non-negative (rotation) or y is negative (vectoring).
        d_pos  = vec ? y[WIDTH-1] : ~z[WIDTH-1];
        // Circular subtracts d*y>>>s from x, hyperbolic adds it.
        x_sub  = d_pos ^ m;
        x_next = x_sub ? (x - y_sh) : (x + y_sh);
        y_next = d_pos ? (y + x_sh) : (y - x_sh);
        z_next = d_pos ? (z - angle) : (z + angle);
    end

endmodule

// File: rtl/cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// cordic_iter_engine
// Iterative CORDIC: one micro-rotation per clock, circular or hyperbolic,
// rotation or vectoring. Outputs carry the CORDIC gain (no compensation).
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               request, taken only while ready=1
//   mode                0 = circular, 1 = hyperbolic
//   vec                 0 = rotation, 1 = vectoring
//   x_in, y_in, z_in    WIDTH signed operands, z in Q3.(WIDTH-3) radians
//   ready               high in IDLE
//   done                one-cycle pulse with fresh x_out/y_out/z_out
//   x_out, y_out, z_out registered results, held until replaced
// Build option: define CORDIC_HYP_REPEAT_EN to run hyperbolic shifts 4 and 13
// twice each (needed for hyperbolic convergence). Circular is unaffected.
// -----------------------------------------------------------------------------
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    vec,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    ready,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

`ifdef CORDIC_HYP_REPEAT_EN
    localparam bit HYP_REPEAT = 1'b1;
`else
    localparam bit HYP_REPEAT = 1'b0;
`endif

    localparam logic [SHIFT_W-1:0] LAST_SHIFT = SHIFT_W'(ITER - 1);

    state_t                  state;
    logic signed [WIDTH-1:0] x_r, y_r, z_r;
    logic signed [WIDTH-1:0] x_n, y_n, z_n;
    logic                    mode_r;
    logic                    vec_r;
    logic [SHIFT_W-1:0]      shift;
    logic                    rep_done;
    logic                    repeat_now;
    logic                    last_step;

    // A repeated shift holds s for one extra step; rep_done marks that the
    // first pass of the pair has already executed.
    assign repeat_now = HYP_REPEAT && mode_r && !rep_done &&
                        (shift == HYP_REPEAT_S_A || shift == HYP_REPEAT_S_B);
    assign last_step  = !repeat_now && (shift == LAST_SHIFT);

    cordic_step #(.WIDTH(WIDTH)) u_step (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .s      (shift),
        .m      (mode_r),
        .vec    (vec_r),
        .x_next (x_n),
        .y_next (y_n),
        .z_next (z_n)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the value from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working registers x_r/y_r/z_r are not reset; they are
            // always loaded on an accepted start before anything reads them.
            state    <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
            z_out    <= '0;
            shift    <= '0;
            rep_done <= 1'b0;
            mode_r   <= 1'b0;
            vec_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_r      <= x_in;
                        y_r      <= y_in;
                        z_r      <= z_in;
                        mode_r   <= mode;
                        vec_r    <= vec;
                        shift    <= first_shift(mode);
                        rep_done <= 1'b0;
                        ready    <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_r <= x_n;
                    y_r <= y_n;
                    z_r <= z_n;
                    if (repeat_now) begin
                        rep_done <= 1'b1;
                    end else begin
                        rep_done <= 1'b0;
                        shift    <= shift + 1'b1;
                    end
                    if (last_step) begin
                        x_out <= x_n;
                        y_out <= y_n;
                        z_out <= z_n;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_engine
// Self-checking bench for cordic_iter_engine (WIDTH=16, ITER=16). A bit-exact
// model of the CORDIC recurrence (angles from $atan/$atanh) feeds a scoreboard
// that a done-monitor drains; table vectors with known answers are also held
// to a +/-4 LSB tolerance, and latency, ready, abort and back-to-back timing
// are checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cordic_iter_engine;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;

`ifdef CORDIC_HYP_REPEAT_EN
    localparam bit HYP_REF = 1'b1;
`else
    localparam bit HYP_REF = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int z;
        int n;
    } exp_t;

    typedef struct {
        logic md;
        logic vc;
        int   x;
        int   y;
        int   z;
        bit   has_ref;
        int   rx;
        int   ry;
        int   rz;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    mode;
    logic                    vec;
    logic signed [WIDTH-1:0] x_in, y_in, z_in;
    logic                    ready;
    logic                    done;
    logic signed [WIDTH-1:0] x_out, y_out, z_out;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    cordic_iter_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .vec   (vec),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .ready (ready),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int want, input int tol);
        n_checks++;
        if (act - want > tol || want - act > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, want, tol);
        end
    endtask

    // Plain recurrence: x' = x - m*d*(y>>>s), y' = y + d*(x>>>s), z' = z - d*angle(s).
    function automatic exp_t model(input logic md, input logic vc, input int xi, input int yi, input int zi);
        exp_t r;
        logic signed [15:0] x, y, z, xn, yn, zn;
        int s, d, mm, ang, n;
        real a;
`ifdef CORDIC_HYP_REPEAT_EN
        bit rep_done;
        rep_done = 1'b0;
`endif
        x  = 16'(xi);
        y  = 16'(yi);
        z  = 16'(zi);
        mm = md ? -1 : 1;
        s  = md ? 1 : 0;
        n  = 0;
        while (s < ITER) begin
            if (vc) d = (y < 0) ? 1 : -1;
            else    d = (z >= 0) ? 1 : -1;
            a   = 1.0 / (2.0 ** s);
            a   = md ? $atanh(a) : $atan(a);
            ang = $rtoi($floor(a * 8192.0));
            xn  = 16'(int'(x) - mm * d * int'(y >>> s));
            yn  = 16'(int'(y) + d * int'(x >>> s));
            zn  = 16'(int'(z) - d * ang);
            x = xn;
            y = yn;
            z = zn;
            n++;
`ifdef CORDIC_HYP_REPEAT_EN
            if (md && (s == 4 || s == 13) && !rep_done) rep_done = 1'b1;
            else begin
                rep_done = 1'b0;
                s++;
            end
`else
            s++;
`endif
        end
        r.x = int'(x);
        r.y = int'(y);
        r.z = int'(z);
        r.n = n;
        return r;
    endfunction

    // Scoreboard drain: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb x_out", int'(x_out), e.x);
                check("sb y_out", int'(y_out), e.y);
                check("sb z_out", int'(z_out), e.z);
            end
        end
    end

    task automatic drive(input vec_t v);
        mode = v.md;
        vec  = v.vc;
        x_in = 16'(v.x);
        y_in = 16'(v.y);
        z_in = 16'(v.z);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ready) check({tag, " ready_timeout"}, 0, 1);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int   cyc  = 0;
        bit   seen = 1'b0;
        e = model(v.md, v.vc, v.x, v.y, v.z);
        wait_ready(tag);
        drive(v);
        start = 1'b1;
        sb.push_back(e);
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
        end
        check({tag, " latency"}, seen ? cyc : -1, e.n + 1);
        if (seen && v.has_ref) begin
            check_tol({tag, " x_ref"}, int'(x_out), v.rx, 4);
            check_tol({tag, " y_ref"}, int'(y_out), v.ry, 4);
            check_tol({tag, " z_ref"}, int'(z_out), v.rz, 4);
        end
        @(posedge clk); #1;
        check({tag, " ready_after_done"}, int'(ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab[8];
        vec_t va, vb;
        exp_t e;
        int   cyc;
        bit   seen;
        int   n_acc, n_done;
        int   t_done[3];

        tab[0] = '{1'b0, 1'b0,  4975,     0,  6434, 1'b1,    5793,  5793,    0};
        tab[1] = '{1'b0, 1'b1,  8192,  8192,     0, 1'b1,   19078,     0, 6434};
        tab[2] = '{1'b1, 1'b0,  9892,     0,  4096, HYP_REF, 9244,  4271,    0};
        tab[3] = '{1'b0, 1'b0,  4975,     0, -6434, 1'b0,       0,     0,    0};
        tab[4] = '{1'b0, 1'b1,  8192, -4096,     0, 1'b0,       0,     0,    0};
        tab[5] = '{1'b1, 1'b1, 12000,  6000,     0, 1'b0,       0,     0,    0};
        tab[6] = '{1'b0, 1'b0, 30000, 30000,     0, 1'b0,       0,     0,    0};
        tab[7] = '{1'b0, 1'b0, -5000,  3000, -2000, 1'b0,       0,     0,    0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; vec = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", int'(ready), 1);
        check("reset done",  int'(done), 0);
        check("reset x_out", int'(x_out), 0);
        check("reset y_out", int'(y_out), 0);
        check("reset z_out", int'(z_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(tab[i], $sformatf("vec%0d", i));
        end

        // start pulsed 5 cycles into RUN with other operands must be ignored.
        va = tab[0];
        vb = '{1'b1, 1'b1, 1000, 2000, -3000, 1'b0, 0, 0, 0};
        e  = model(va.md, va.vc, va.x, va.y, va.z);
        wait_ready("ignore");
        drive(va);
        start = 1'b1;
        sb.push_back(e);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == 5);
            if (cyc == 5) begin
                drive(vb);
                check("ignore ready_in_run", int'(ready), 0);
            end
            if (done) seen = 1'b1;
        end
        check("ignore latency", seen ? cyc : -1, e.n + 1);
        check_tol("ignore x_ref", int'(x_out), 5793, 4);
        check_tol("ignore y_ref", int'(y_out), 5793, 4);

        // Reset 8 cycles into RUN aborts the operation without a done pulse.
        wait_ready("abort");
        drive(tab[1]);
        start = 1'b1;
        sb.push_back(model(tab[1].md, tab[1].vc, tab[1].x, tab[1].y, tab[1].z));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort ready", int'(ready), 1);
        check("abort done",  int'(done), 0);
        check("abort x_out", int'(x_out), 0);
        check("abort y_out", int'(y_out), 0);
        check("abort z_out", int'(z_out), 0);
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort no_done", n_done, 0);

        // start held high: each op is accepted the cycle ready rises.
        wait_ready("b2b");
        drive(tab[0]);
        e = model(tab[0].md, tab[0].vc, tab[0].x, tab[0].y, tab[0].z);
        start = 1'b1;
        n_acc = 0; n_done = 0;
        for (int c = 0; c < 200 && n_done < 3; c++) begin
            if (ready && start && n_acc < 3) begin
                sb.push_back(e);
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 3) start = 1'b0;
            if (done) begin
                t_done[n_done] = c;
                n_done++;
            end
        end
        check("b2b done_count", n_done, 3);
        if (n_done == 3) begin
            check("b2b gap1", t_done[1] - t_done[0], 18);
            check("b2b gap2", t_done[2] - t_done[1], 18);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
